// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges the single-cycle ALU result path and a FIFO of
// long-latency results onto the register file's single write port, and keeps
// a pending-register scoreboard so decode can stall on in-flight operands.
// Optional feature macro: WB_BYPASS_EN (long result straight to the write
// port when the FIFO is empty and the ALU is idle).
module wb_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_reg,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          lng_valid,
    output logic                          lng_ready,
    input  logic [ADDR_W-1:0]             lng_reg,
    input  logic [DATA_W-1:0]             lng_data,
    input  logic                          iss_valid,
    input  logic [ADDR_W-1:0]             iss_reg,
    input  logic [ADDR_W-1:0]             chk_a,
    input  logic [ADDR_W-1:0]             chk_b,
    output logic                          stall,
    output logic                          alu_hold,
    output logic                          WE,
    output logic [ADDR_W-1:0]             WrReg,
    output logic [DATA_W-1:0]             InData,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    logic [ADDR_W-1:0] reg_mem_q  [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              hold_q, hold_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wrreg_q, wrreg_d;
    logic [DATA_W-1:0] indata_q, indata_d;

    logic alu_win, nonempty, accept, pop, push, bypass;
    logic [ADDR_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data;

    // Arbitration decisions for this cycle
    always_comb begin
        alu_win   = alu_valid && (alu_reg != '0);
        nonempty  = (count_q != '0);
        lng_ready = !reset && (count_q < DEPTH_C);
        accept    = lng_valid && lng_ready;
        pop       = !alu_win && nonempty;
`ifdef WB_BYPASS_EN
        bypass    = !nonempty && !alu_win && accept && (lng_reg != '0);
`else
        bypass    = 1'b0;
`endif
        push      = accept && (lng_reg != '0) && !bypass;
        head_reg  = reg_mem_q[rd_ptr_q];
        head_data = data_mem_q[rd_ptr_q];
        stall     = pend_q[chk_a] | pend_q[chk_b];
    end

    // Next-state: write port, FIFO pointers/count, scoreboard, starvation guard
    always_comb begin
        we_d     = 1'b0;
        wrreg_d  = wrreg_q;
        indata_d = indata_q;
        if (alu_win) begin
            we_d     = 1'b1;
            wrreg_d  = alu_reg;
            indata_d = alu_data;
        end else if (pop) begin
            we_d     = 1'b1;
            wrreg_d  = head_reg;
            indata_d = head_data;
        end else if (bypass) begin
            we_d     = 1'b1;
            wrreg_d  = lng_reg;
            indata_d = lng_data;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Clears first so a same-cycle issue to the same register wins
        pend_d = pend_q;
        if (pop)    pend_d[head_reg] = 1'b0;
        if (bypass) pend_d[lng_reg]  = 1'b0;
        if (iss_valid && (iss_reg != '0)) pend_d[iss_reg] = 1'b1;

        // Pop and ALU win are exclusive, so any non-ALU-starving cycle clears
        starve_d = '0;
        hold_d   = 1'b0;
        if (alu_win && nonempty) begin
            if (starve_q == STARVE_LAST) hold_d = 1'b1;
            else                         starve_d = starve_q + SW'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            hold_q   <= 1'b0;
            pend_q   <= '0;
            we_q     <= 1'b0;
            wrreg_q  <= '0;
            indata_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            we_q     <= we_d;
            wrreg_q  <= wrreg_d;
            indata_q <= indata_d;
        end
    end

    // FIFO storage; contents are don't-care once the count is cleared
    always_ff @(posedge clock) begin
        if (push) begin
            reg_mem_q[wr_ptr_q]  <= lng_reg;
            data_mem_q[wr_ptr_q] <= lng_data;
        end
    end

    // Output drive
    always_comb begin
        WE         = we_q;
        WrReg      = wrreg_q;
        InData     = indata_q;
        alu_hold   = hold_q;
        fifo_count = count_q;
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (default parameters).
module tb_wb_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        lng_valid;
    logic        lng_ready;
    logic [4:0]  lng_reg;
    logic [31:0] lng_data;
    logic        iss_valid;
    logic [4:0]  iss_reg;
    logic [4:0]  chk_a;
    logic [4:0]  chk_b;
    logic        stall;
    logic        alu_hold;
    logic        WE;
    logic [4:0]  WrReg;
    logic [31:0] InData;
    logic [2:0]  fifo_count;

    int vectors = 0;
    int miscompares = 0;

    wb_write_arbiter #(
        .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .STARVE_MAX(4)
    ) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_reg(lng_reg), .lng_data(lng_data),
        .iss_valid(iss_valid), .iss_reg(iss_reg),
        .chk_a(chk_a), .chk_b(chk_b), .stall(stall), .alu_hold(alu_hold),
        .WE(WE), .WrReg(WrReg), .InData(InData), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic port(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        check({tag, ".WE"}, 64'(WE), 64'(we));
        check({tag, ".WrReg"}, 64'(WrReg), 64'(r));
        check({tag, ".InData"}, 64'(InData), 64'(d));
    endtask

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        lng_valid = 1'b0; lng_reg = '0; lng_data = '0;
        iss_valid = 1'b0; iss_reg = '0; chk_a = '0; chk_b = '0;

        // 1: reset state and a plain ALU write
        tick(); tick();
        check("rst.lng_ready", 64'(lng_ready), 64'd0);
        port("rst", 1'b0, 5'd0, 32'h0);
        check("rst.alu_hold", 64'(alu_hold), 64'd0);
        check("rst.count", 64'(fifo_count), 64'd0);
        reset = 1'b0; #1;
        check("idle.lng_ready", 64'(lng_ready), 64'd1);
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h11;
        tick();
        port("alu3", 1'b1, 5'd3, 32'h11);
        alu_valid = 1'b0;
        tick();
        port("alu_hold_vals", 1'b0, 5'd3, 32'h11);

        // 2: issue 5, long result 5/0xAA with ALU idle
        iss_valid = 1'b1; iss_reg = 5'd5;
        tick();
        iss_valid = 1'b0; chk_a = 5'd5; #1;
        check("t2.stall_pre", 64'(stall), 64'd1);
        lng_valid = 1'b1; lng_reg = 5'd5; lng_data = 32'hAA;
        tick();
        lng_valid = 1'b0;
`ifdef WB_BYPASS_EN
        port("t2.bypass", 1'b1, 5'd5, 32'hAA);
        check("t2.count", 64'(fifo_count), 64'd0);
        check("t2.stall_post", 64'(stall), 64'd0);
`else
        port("t2.N", 1'b0, 5'd3, 32'h11);
        check("t2.count", 64'(fifo_count), 64'd1);
        check("t2.stall_mid", 64'(stall), 64'd1);
        tick();
        port("t2.N1", 1'b1, 5'd5, 32'hAA);
        check("t2.count_post", 64'(fifo_count), 64'd0);
        check("t2.stall_post", 64'(stall), 64'd0);
`endif
        tick();

        // 3+4: fill FIFO with ALU busy, starvation hold, drain in order
        alu_valid = 1'b1; alu_reg = 5'd1;
        for (int i = 0; i < 4; i++) begin
            lng_valid = 1'b1; lng_reg = 5'(8 + i); lng_data = 32'hB0 + 32'(i);
            alu_data = 32'h100 + 32'(i);
            tick();
        end
        check("t3.count_full", 64'(fifo_count), 64'd4);
        lng_reg = 5'd12; lng_data = 32'hBC; #1;
        check("t3.ready_full", 64'(lng_ready), 64'd0);
        check("t4.hold_pre", 64'(alu_hold), 64'd0);
        alu_data = 32'h104;
        tick();
        check("t4.hold", 64'(alu_hold), 64'd1);
        check("t3.count_held", 64'(fifo_count), 64'd4);
        port("t4.alu_wins", 1'b1, 5'd1, 32'h104);
        alu_data = 32'h105;
        tick();
        check("t4.hold_one_cycle", 64'(alu_hold), 64'd0);
        check("t4.count", 64'(fifo_count), 64'd4);
        alu_valid = 1'b0;
        tick();
        port("t3.pop8", 1'b1, 5'd8, 32'hB0);
        check("t3.count3", 64'(fifo_count), 64'd3);
        tick();
        lng_valid = 1'b0;
        port("t3.pop9", 1'b1, 5'd9, 32'hB1);
        check("t3.pushpop_count", 64'(fifo_count), 64'd3);
        tick();
        port("t3.pop10", 1'b1, 5'd10, 32'hB2);
        tick();
        port("t3.pop11", 1'b1, 5'd11, 32'hB3);
        tick();
        port("t3.pop12", 1'b1, 5'd12, 32'hBC);
        check("t3.count_empty", 64'(fifo_count), 64'd0);
        tick();
        port("t3.idle", 1'b0, 5'd12, 32'hBC);

        // 5: alu_reg==0 lets the FIFO pop; lng_reg==0 is consumed, not pushed
        alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'h22;
        lng_valid = 1'b1; lng_reg = 5'd7; lng_data = 32'h77;
        tick();
        port("t5.alu2", 1'b1, 5'd2, 32'h22);
        check("t5.count1", 64'(fifo_count), 64'd1);
        alu_reg = 5'd0; alu_data = 32'hDEAD;
        lng_reg = 5'd0; lng_data = 32'h55; #1;
        check("t5.ready", 64'(lng_ready), 64'd1);
        tick();
        port("t5.pop7", 1'b1, 5'd7, 32'h77);
        check("t5.count0", 64'(fifo_count), 64'd0);
        alu_valid = 1'b0;
        tick();
        lng_valid = 1'b0;
        port("t5.reg0_dropped", 1'b0, 5'd7, 32'h77);
        check("t5.count_unch", 64'(fifo_count), 64'd0);

        // Same-cycle set and clear of register 9: set wins
        iss_valid = 1'b1; iss_reg = 5'd9;
        tick();
        iss_valid = 1'b0; chk_a = 5'd9; #1;
        check("sw.stall_set", 64'(stall), 64'd1);
        lng_valid = 1'b1; lng_reg = 5'd9; lng_data = 32'h99;
        tick();
        lng_valid = 1'b0;
        iss_valid = 1'b1; iss_reg = 5'd9;
        tick();
        iss_valid = 1'b0;
        check("sw.stall_kept", 64'(stall), 64'd1);
        check("sw.WrReg", 64'(WrReg), 64'd9);
        check("sw.InData", 64'(InData), 64'h99);

        // 6: reset mid-operation with 3 buffered results and pend 0xF0
        alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h1;
        for (int i = 0; i < 3; i++) begin
            iss_valid = 1'b1; iss_reg = 5'(4 + i);
            lng_valid = 1'b1; lng_reg = 5'(20 + i); lng_data = 32'h200 + 32'(i);
            tick();
        end
        lng_valid = 1'b0; iss_reg = 5'd7;
        tick();
        iss_valid = 1'b0;
        check("t6.count3", 64'(fifo_count), 64'd3);
        chk_a = 5'd4; chk_b = 5'd0; #1;
        check("t6.stall4", 64'(stall), 64'd1);
        chk_a = 5'd0; chk_b = 5'd7; #1;
        check("t6.stall7", 64'(stall), 64'd1);
        reset = 1'b1; alu_valid = 1'b0; #1;
        check("t6.ready_rst", 64'(lng_ready), 64'd0);
        tick();
        check("t6.count_rst", 64'(fifo_count), 64'd0);
        check("t6.WE_rst", 64'(WE), 64'd0);
        check("t6.hold_rst", 64'(alu_hold), 64'd0);
        chk_b = 5'd0;
        for (int r = 0; r < 32; r++) begin
            chk_a = 5'(r); #1;
            check($sformatf("t6.pend%0d", r), 64'(stall), 64'd0);
        end
        reset = 1'b0;
        tick();
        check("t6.WE_after", 64'(WE), 64'd0);
        check("t6.count_after", 64'(fifo_count), 64'd0);
        tick();
        check("t6.WE_after2", 64'(WE), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
